centroid_divider: RTL

CENTROID_DIVIDER -- requirements
Module: centroid_divider

---
 rtl/kmeans_pkg.sv | 19 +
 rtl/seq_divider.sv | 64 ++++++
 rtl/centroid_divider.sv | 138 +++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
// Shared constants and FSM encoding for the k-means centroid update datapath.
package kmeans_pkg;

    localparam int K        = 16;
    localparam int SW       = 24;
    localparam int CW       = 12;
    localparam int PIX_W    = 24;
    localparam int DIV_ITER = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DIV,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, result
// saturated to 8 bits once all dividend bits have been shifted through.
module seq_divider #(
    parameter int SW = 24,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [SW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [7:0]    quotient
);

    localparam int ITER  = kmeans_pkg::DIV_ITER;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    // quo_q starts as the dividend and fills with quotient bits from the bottom.
    logic [SW-1:0]    quo_q;
    logic [CW-1:0]    rem_q;
    logic [CW-1:0]    dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    logic [CW:0] partial;
    logic        fits;

    assign partial  = {rem_q, quo_q[SW-1]};
    assign fits     = (partial >= {1'b0, dvs_q});
    assign busy     = run_q;
    // done marks the cycle whose closing edge writes the final quotient bit.
    assign done     = run_q && (cnt_q == LAST);
    assign quotient = (|quo_q[SW-1:8]) ? 8'hFF : quo_q[7:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            // When the trial fails, partial < divisor so its top bit is zero.
            rem_q <= fits ? CW'(partial - {1'b0, dvs_q}) : partial[CW-1:0];
            quo_q <= {quo_q[SW-2:0], fits};
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/centroid_divider.sv
// Walks every active cluster, divides its colour sums by its pixel count and
// writes the new mean, reporting whether any mean moved.
module centroid_divider #(
    parameter int K  = kmeans_pkg::K,
    parameter int SW = kmeans_pkg::SW,
    parameter int CW = kmeans_pkg::CW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      k_active,
    output logic [3:0]      acc_idx,
    input  logic [3*SW-1:0] acc_sum,
    input  logic [CW-1:0]   acc_count,
    input  logic [23:0]     old_mean,
    output logic            mean_we,
    output logic [3:0]      mean_idx,
    output logic [23:0]     mean_wdata,
    output logic            busy,
    output logic            done,
    output logic            all_stable
);

    import kmeans_pkg::*;

    state_t           state;
    logic [3:0]       last_idx;
    logic             changed;
    logic [PIX_W-1:0] old_mean_q;
    logic             count_zero_q;

    logic [4:0] k_eff;
    logic       div_load;
    logic [2:0] ch_busy;
    logic [2:0] ch_done;
    logic [7:0] ch_quot [3];
    logic       div_busy;
    logic       div_done;
    logic       wdata_changed;

    assign k_eff    = (k_active > 5'(K)) ? 5'(K) : k_active;
    assign div_load = (state == S_LOAD);
    assign div_busy = |ch_busy;
    assign div_done = &ch_done;

    // acc_sum packs {R,G,B}, so channel 0 is blue and channel 2 is red.
    for (genvar ch = 0; ch < 3; ch++) begin : g_div
        seq_divider #(
            .SW(SW),
            .CW(CW)
        ) u_div (
            .clk     (clk),
            .reset   (reset),
            .load    (div_load),
            .dividend(acc_sum[ch*SW +: SW]),
            .divisor (acc_count),
            .busy    (ch_busy[ch]),
            .done    (ch_done[ch]),
            .quotient(ch_quot[ch])
        );
    end

    // The dividers still run for an empty cluster so timing stays fixed; the
    // result is simply replaced by the captured old mean.
    assign mean_wdata    = count_zero_q ? old_mean_q : {ch_quot[2], ch_quot[1], ch_quot[0]};
    assign wdata_changed = (mean_wdata != old_mean_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            acc_idx      <= '0;
            mean_idx     <= '0;
            mean_we      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            all_stable   <= 1'b0;
            last_idx     <= '0;
            changed      <= 1'b0;
            old_mean_q   <= '0;
            count_zero_q <= 1'b0;
        end else begin
            case (state)
                // start is honoured in the done cycle too, since busy is low there.
                S_IDLE, S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (start) begin
                        if (k_eff == '0) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            all_stable <= 1'b1;
                        end else begin
                            state      <= S_FETCH;
                            busy       <= 1'b1;
                            acc_idx    <= '0;
                            last_idx   <= 4'(k_eff - 5'd1);
                            changed    <= 1'b0;
                            all_stable <= 1'b0;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    old_mean_q   <= old_mean;
                    count_zero_q <= (acc_count == '0);
                    state        <= S_DIV;
                end
                S_DIV: begin
                    // Leaving on an idle divider keeps the FSM from stalling forever.
                    if (div_done || !div_busy) begin
                        state    <= S_WRITE;
                        mean_we  <= 1'b1;
                        mean_idx <= acc_idx;
                    end
                end
                S_WRITE: begin
                    mean_we <= 1'b0;
                    changed <= changed | wdata_changed;
                    if (acc_idx == last_idx) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        all_stable <= !(changed | wdata_changed);
                    end else begin
                        state   <= S_FETCH;
                        acc_idx <= acc_idx + 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
